// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the five-stage MIPS pipeline front end.
//   PC_W           : program-counter width
//   NOP_INST       : encoding written into IF/ID for a bubble (sll $0,$0,0)
//   fetch_state_e  : instruction-fetch FSM states
//     RST       - one cycle after reset release, no fetch request
//     FETCH     - normal fetching, one word per cycle on a hit
//     MISS      - cache miss in progress, request held stable
//     MISS_KILL - cache miss in progress and a redirect is pending; the word
//                 returned at the end of the miss is wrong-path and dropped
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        RST       = 2'd0,
        FETCH     = 2'd1,
        MISS      = 2'd2,
        MISS_KILL = 2'd3
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Loads a fetched instruction and its PC+4 when
// wr_en is high; if flush is also high the register is loaded with a bubble
// (NOP, pc4=0, valid=0) instead. Holds its contents while wr_en is low.
//
// Ports:
//   clk      in   pipeline clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears to a bubble)
//   wr_en    in   update enable
//   flush    in   load a bubble instead of inst_in/pc4_in
//   inst_in  in   fetched instruction word
//   pc4_in   in   PC+4 of the fetched instruction
//   inst     out  registered instruction
//   pc4      out  registered PC+4
//   valid    out  1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module if_id_reg (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            flush,
    input  logic [31:0]     inst_in,
    input  logic [PC_W-1:0] pc4_in,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] pc4,
    output logic            valid
);

    logic [31:0]     inst_reg;
    logic [PC_W-1:0] pc4_reg;
    logic            valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_reg  <= NOP_INST;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (wr_en) begin
            if (flush) begin
                inst_reg  <= NOP_INST;
                pc4_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                inst_reg  <= inst_in;
                pc4_reg   <= pc4_in;
                valid_reg <= 1'b1;
            end
        end
    end

    assign inst  = inst_reg;
    assign pc4   = pc4_reg;
    assign valid = valid_reg;

endmodule : if_id_reg

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC,
// issues word fetches to the instruction cache, applies redirects resolved
// in ID (beq taken, j/jal, jr/jalr) and the IF/ID flush, honours the
// load-use stall (hz_stall) and the data-cache stall (mem_stall), and
// tracks instruction-cache misses so that a redirect arriving mid-miss never
// lets the wrong-path word into IF/ID.
//
// Parameters:
//   RESET_PC          PC value after reset
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ID_PCSrc          beq resolved taken in ID
//   ID_Jump           j/jal in ID
//   ID_JumpR          jr/jalr in ID
//   ID_IF_Flush       squash IF/ID at the next update
//   ID_branch_target  beq target
//   ID_rs_data        jr/jalr target
//   hz_stall          load-use stall: hold PC, IF/ID and FSM
//   mem_stall         data-cache stall: freeze the whole stage
//   ICACHE_ren        fetch request
//   ICACHE_addr       word address PC[31:2]
//   ICACHE_stall      miss in progress (request must stay stable)
//   ICACHE_rdata      fetched word, valid when ren=1 and stall=0
//   IF_ID_inst        instruction to decode
//   IF_ID_pc4         PC+4 of that instruction
//   IF_ID_valid       1 = real instruction, 0 = bubble
//
// Optional build macro IF_PERF_CNT_EN adds three wrapping 32-bit counters:
//   perf_fetch_cnt    valid words written into IF/ID
//   perf_flush_cnt    IF/ID flushes requested by ID and applied
//   perf_miss_cycles  cycles with ICACHE_stall=1 while ICACHE_ren=1
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_PCSrc,
    input  logic        ID_Jump,
    input  logic        ID_JumpR,
    input  logic        ID_IF_Flush,
    input  logic [31:0] ID_branch_target,
    input  logic [31:0] ID_rs_data,
    input  logic        hz_stall,
    input  logic        mem_stall,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_miss_cycles
`endif
);

    fetch_state_e    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pend_reg, pend_next;   // redirect target owed after a miss

    logic            advance;      // PC/IF/ID/FSM may move this cycle
    logic            redir;
    logic [PC_W-1:0] redir_target;
    logic [PC_W-1:0] pc_plus4;
    logic            delivered;    // cache handed back a word this cycle
    logic            ifid_flush;

    // Stage can only move when neither the load-use nor data-cache stall holds it.
    assign advance  = ~hz_stall & ~mem_stall;
    assign redir    = (ID_JumpR | ID_Jump | ID_PCSrc) & advance;
    assign pc_plus4 = pc_reg + 32'd4;

    // jr wins over j, j wins over beq.
    always_comb begin
        redir_target = ID_branch_target;
        if (ID_JumpR) begin
            redir_target = ID_rs_data;
        end else if (ID_Jump) begin
            redir_target = {IF_ID_pc4[31:28], IF_ID_inst[25:0], 2'b00};
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RST: state_next = FETCH;
            FETCH, MISS: begin
                if (advance) begin
                    if (ICACHE_stall) begin
                        state_next = redir ? MISS_KILL : MISS;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            MISS_KILL: begin
                if (advance && !ICACHE_stall) begin
                    state_next = FETCH;
                end
            end
            default: state_next = RST;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        ICACHE_ren = 1'b1;
        if (state_reg == RST) begin
            ICACHE_ren = 1'b0;
        end
    end

    // The address follows the PC in every state, so it is stable throughout a
    // miss because the PC only moves when the cache is not stalling.
    assign ICACHE_addr = pc_reg[31:2];
    assign delivered   = ICACHE_ren & ~ICACHE_stall;

    // ---------------------------------------------------------------------
    // PC and pending-target datapath
    // ---------------------------------------------------------------------
    always_comb begin
        pc_next   = pc_reg;
        pend_next = pend_reg;
        if (advance) begin
            case (state_reg)
                FETCH, MISS: begin
                    if (ICACHE_stall) begin
                        if (redir) begin
                            pend_next = redir_target;
                        end
                    end else begin
                        pc_next = redir ? redir_target : pc_plus4;
                    end
                end
                MISS_KILL: begin
                    if (ICACHE_stall) begin
                        if (redir) begin
                            pend_next = redir_target;
                        end
                    end else begin
                        // A redirect in the very cycle the miss ends is newer
                        // than the pending one.
                        pc_next = redir ? redir_target : pend_reg;
                    end
                end
                default: begin
                    pc_next   = pc_reg;
                    pend_next = pend_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg   <= RESET_PC;
            pend_reg <= '0;
        end else begin
            pc_reg   <= pc_next;
            pend_reg <= pend_next;
        end
    end

    // ---------------------------------------------------------------------
    // IF/ID register
    // ---------------------------------------------------------------------
    // A word is dropped when ID squashes IF, when nothing came back, or when
    // the returning word belongs to a miss that a redirect already killed.
    assign ifid_flush = ID_IF_Flush | ~delivered |
                        (state_reg == RST) | (state_reg == MISS_KILL);

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (advance),
        .flush   (ifid_flush),
        .inst_in (ICACHE_rdata),
        .pc4_in  (pc_plus4),
        .inst    (IF_ID_inst),
        .pc4     (IF_ID_pc4),
        .valid   (IF_ID_valid)
    );

`ifdef IF_PERF_CNT_EN
    // ---------------------------------------------------------------------
    // Performance counters (wrapping)
    // ---------------------------------------------------------------------
    logic [2:0] perf_evt;

    assign perf_evt[0] = advance & ~ifid_flush;
    assign perf_evt[1] = advance & ID_IF_Flush;
    assign perf_evt[2] = ICACHE_ren & ICACHE_stall;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (perf_evt[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_fetch_cnt   = g_perf[0].cnt_reg;
    assign perf_flush_cnt   = g_perf[1].cnt_reg;
    assign perf_miss_cycles = g_perf[2].cnt_reg;
`endif

endmodule : if_fetch_stage
